fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side controller of the async FIFO. It runs in the write clock domain and produces the memory write strobe and address. It keeps a binary and a Gray write pointer and detects full against the read pointer, which arrives already synchronised into this domain. It exports a registered Gray pointer to the read-domain synchroniser, plus fill level, almost-full and an optional overflow flag.

Parameters:
bus_width, 8, data word width (passed through to the memory write port).
addr_width, 3, memory address width; depth = 2**addr_width.
afull_thresh, 6, level at or above which w_afull asserts; legal range 1..depth.

Ports:
w_clk  input  1  write-domain clock, rising edge.
w_rst  input  1  synchronous, active-high reset.
w_en  input  1  write request from producer.
w_data  input  bus_width  write data.
rptr_sync  input  addr_width+1  Gray read pointer, already double-flopped into w_clk.
w_inc  output  1  memory write strobe.
w_addr  output  addr_width  memory write address.
w_data_out  output  bus_width  memory write data.
wptr_out  output  addr_width+1  registered Gray write pointer, to the read-domain synchroniser.
w_full  output  1  FIFO full.
w_afull  output  1  almost full.
w_level  output  addr_width+1  occupancy seen from the write domain, 0..depth.
w_ovf  output  1  sticky overflow flag.

Behaviour:
- One clock, w_clk; reset is synchronous and active-high (w_rst).
- Reset values on the w_clk edge with w_rst=1: wbin=0, wptr_out=0. This gives w_addr=0, w_full=0, w_afull=0, w_level=0, w_ovf=0, w_inc=0. Reset takes priority over w_en.
- Combinational outputs:
  - w_inc = w_en & ~w_full.
  - w_data_out = w_data.
  - w_addr = wbin[addr_width-1:0].
- Pointer update, on each edge with w_inc=1:
  - wbin <= wbin+1, modulo 2**(addr_width+1), wrapping naturally.
  - wptr_out <= gray(wbin+1), where gray(x) = x ^ (x>>1).
  - wptr_out comes straight from a flop with no combinational logic after it; this is mandatory for CDC.
- Full detection (combinational from wptr_out and rptr_sync): w_full=1 when the two MSBs of wptr_out are the inverse of the two MSBs of rptr_sync and all remaining bits are equal.
- Level:
  - w_level = (wbin - bin(rptr_sync)) mod 2**(addr_width+1), where bin() is Gray-to-binary.
  - w_level=depth exactly when w_full=1.
  - w_afull = (w_level >= afull_thresh).
- Latency: a write accepted on edge N is reflected in w_level, w_full and wptr_out after edge N; the write lands in memory at that same edge.
- Full with w_en=1: no pointer change, w_inc=0, data dropped.
- Read pointer advancing while full: w_full deasserts combinationally in the cycle rptr_sync changes. A write in that same cycle is accepted.
- Status is pessimistic: rptr_sync lags the true read pointer by at least 2 cycles, so w_full/w_level may overstate occupancy but never understate it.
- Reset mid-stream: pointers return to 0 regardless of w_en. The read domain must be reset in the same window.

Optional Feature:
FIFO_WR_OVF_EN:
- Defined: w_ovf is set on any edge where w_en=1 and w_full=1, and stays set until w_rst.
- Undefined: w_ovf is tied to 0 and no flop is instantiated.

Decomposition:
- Shared package/header fifo_pkg holds:
  - default bus_width and addr_width;
  - derived DEPTH and PTR_W = addr_width+1;
  - constants shared with the read side.
- One sub-module, grey_bin: combinational parameterised Gray-to-binary converter (PTR_W wide), used for rptr_sync.
- Binary-to-Gray is inline.

Test Plan:
1. Reset with w_rst=1 for one edge while w_en=1 -> wptr_out=0, w_addr=0, w_level=0, w_full=0, w_afull=0, w_ovf=0.
2. rptr_sync=0, 8 back-to-back writes -> wptr_out goes 1,3,2,6,7,5,4,12. w_addr goes 0..7. w_afull=1 from level 6. After the 8th write: w_full=1, w_level=8.
3. Full, w_en=1 for 2 cycles -> w_inc=0, wptr_out holds at 12, w_addr=0. w_ovf=1 with FIFO_WR_OVF_EN defined, 0 without.
4. Full, then rptr_sync set to gray(3)=2 -> same cycle: w_full=0, w_level=5, w_afull=0. A write that cycle is accepted, giving w_level=6, w_afull=1.
5. Wrap: alternate writes with rptr_sync tracking wbin-2 for 20 writes -> wbin goes 15->0 with wptr_out 8->0. w_level stays 2 and w_full stays 0 throughout.
6. Mid-stream reset at level 5 with w_en=1 -> next edge: all outputs at reset values, w_ovf cleared. A write on the following edge gives wptr_out=1, w_addr=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async FIFO widths, depth and synchroniser constants for the write and read sides.
package fifo_pkg;
  localparam int BUS_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam int SYNC_STAGES = 2;
  localparam int AFULL_THRESH = 6;
endpackage

// File: rtl/grey_bin.sv
// grey_bin: combinational Gray-to-binary converter.
module grey_bin
  import fifo_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-side pointers, full, level and almost-full detection.
// Defining FIFO_WR_OVF_EN adds a sticky overflow flag on w_ovf; otherwise w_ovf is tied low.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int bus_width = BUS_WIDTH,
  parameter int addr_width = ADDR_WIDTH,
  parameter int afull_thresh = AFULL_THRESH
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_en,
  input  logic [bus_width-1:0]  w_data,
  input  logic [addr_width:0]   rptr_sync,
  output logic                  w_inc,
  output logic [addr_width-1:0] w_addr,
  output logic [bus_width-1:0]  w_data_out,
  output logic [addr_width:0]   wptr_out,
  output logic                  w_full,
  output logic                  w_afull,
  output logic [addr_width:0]   w_level,
  output logic                  w_ovf
);
  localparam int PW = addr_width + 1;
  localparam logic [PW-1:0] AFULL_T = PW'(afull_thresh);
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};
  logic [PW-1:0] wbin, wbin_nxt, rbin;
  grey_bin #(.W(PW)) u_rptr_bin (.gray(rptr_sync), .bin(rbin));
  assign wbin_nxt = wbin + 1'b1;
  // full compares the registered Gray pointers so no extra conversion sits on the full path
  assign w_full = wptr_out == (rptr_sync ^ FULL_MASK);
  assign w_inc = w_en & ~w_full;
  assign w_addr = wbin[addr_width-1:0];
  assign w_data_out = w_data;
  assign w_level = wbin - rbin;
  assign w_afull = w_level >= AFULL_T;
  // wptr_out leaves straight from a flop so the read-domain synchroniser sees a glitch-free Gray code
  always_ff @(posedge w_clk)
    if (w_rst) begin
      wbin <= '0;
      wptr_out <= '0;
    end else if (w_inc) begin
      wbin <= wbin_nxt;
      wptr_out <= wbin_nxt ^ (wbin_nxt >> 1);
    end
`ifdef FIFO_WR_OVF_EN
  logic ovf;
  always_ff @(posedge w_clk)
    ovf <= w_rst ? 1'b0 : ovf | (w_en & w_full);
  assign w_ovf = ovf;
`else
  assign w_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed self-checking bench for fifo_wr_ctrl (honours FIFO_WR_OVF_EN).
module tb_fifo_wr_ctrl;
  logic       w_clk = 1'b0;
  logic       w_rst, w_en, w_inc, w_full, w_afull, w_ovf;
  logic [7:0] w_data, w_data_out;
  logic [3:0] rptr_sync, wptr_out, w_level;
  logic [2:0] w_addr;
  int checks = 0;
  int errors = 0;
`ifdef FIFO_WR_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  fifo_wr_ctrl #(.bus_width(8), .addr_width(3), .afull_thresh(6)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_en(w_en), .w_data(w_data), .rptr_sync(rptr_sync),
    .w_inc(w_inc), .w_addr(w_addr), .w_data_out(w_data_out), .wptr_out(wptr_out),
    .w_full(w_full), .w_afull(w_afull), .w_level(w_level), .w_ovf(w_ovf)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [3:0] gray(input logic [3:0] x);
    return x ^ (x >> 1);
  endfunction

  task automatic do_reset();
    @(negedge w_clk);
    w_rst = 1'b1; w_en = 1'b1; rptr_sync = 4'd0; w_data = 8'h00;
    @(posedge w_clk); #1;
    w_rst = 1'b0; w_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (wptr_out !== 4'd0) begin errors++; $display("FAIL reset_wptr got %0d want 0", wptr_out); end
    checks++; if (w_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", w_addr); end
    checks++; if (w_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d want 0", w_level); end
    checks++; if (w_full !== 1'b0 || w_afull !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b want 00", w_full, w_afull); end
    checks++; if (w_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", w_ovf); end
    checks++; if (w_inc !== 1'b0) begin errors++; $display("FAIL reset_inc got %b want 0", w_inc); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_wptr [8] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    for (int k = 0; k < 8; k++) begin
      @(negedge w_clk);
      w_en = 1'b1; w_data = 8'(8'hA0 + k);
      #1;
      checks++; if (w_inc !== 1'b1 || w_addr !== 3'(k)) begin errors++; $display("FAIL fill_pre%0d inc/addr got %b/%0d want 1/%0d", k, w_inc, w_addr, k); end
      checks++; if (w_data_out !== 8'(8'hA0 + k)) begin errors++; $display("FAIL fill_data%0d got %h want %h", k, w_data_out, 8'(8'hA0 + k)); end
      @(posedge w_clk); #1;
      checks++; if (wptr_out !== exp_wptr[k]) begin errors++; $display("FAIL fill_wptr%0d got %0d want %0d", k, wptr_out, exp_wptr[k]); end
      checks++; if (w_level !== 4'(k + 1)) begin errors++; $display("FAIL fill_level%0d got %0d want %0d", k, w_level, k + 1); end
      checks++; if (w_afull !== (k + 1 >= 6)) begin errors++; $display("FAIL fill_afull%0d got %b want %b", k, w_afull, k + 1 >= 6); end
      checks++; if (w_full !== (k == 7)) begin errors++; $display("FAIL fill_full%0d got %b want %b", k, w_full, k == 7); end
    end
    w_en = 1'b0;
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 2; k++) begin
      @(negedge w_clk);
      w_en = 1'b1; #1;
      checks++; if (w_inc !== 1'b0 || w_addr !== 3'd0) begin errors++; $display("FAIL ovf_pre%0d inc/addr got %b/%0d want 0/0", k, w_inc, w_addr); end
      @(posedge w_clk); #1;
      checks++; if (wptr_out !== 4'd12 || w_level !== 4'd8 || w_full !== 1'b1) begin
        errors++; $display("FAIL ovf_hold%0d wptr/level/full got %0d/%0d/%b want 12/8/1", k, wptr_out, w_level, w_full); end
    end
    w_en = 1'b0;
    checks++; if (w_ovf !== OVF_EXP) begin errors++; $display("FAIL ovf_flag got %b want %b", w_ovf, OVF_EXP); end
  endtask

  task automatic test_read_release();
    @(negedge w_clk);
    rptr_sync = 4'd2; #1;
    checks++; if (w_full !== 1'b0 || w_level !== 4'd5 || w_afull !== 1'b0) begin
      errors++; $display("FAIL release full/level/afull got %b/%0d/%b want 0/5/0", w_full, w_level, w_afull); end
    w_en = 1'b1; #1;
    checks++; if (w_inc !== 1'b1) begin errors++; $display("FAIL release_inc got %b want 1", w_inc); end
    @(posedge w_clk); #1;
    w_en = 1'b0;
    checks++; if (w_level !== 4'd6 || w_afull !== 1'b1 || wptr_out !== 4'd13) begin
      errors++; $display("FAIL release_write level/afull/wptr got %0d/%b/%0d want 6/1/13", w_level, w_afull, wptr_out); end
    checks++; if (w_ovf !== OVF_EXP) begin errors++; $display("FAIL release_ovf got %b want %b", w_ovf, OVF_EXP); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int b = 0; b < 20; b++) begin
      @(negedge w_clk);
      rptr_sync = gray(4'(b - 2)); w_en = 1'b1; #1;
      checks++; if (w_level !== 4'd2 || w_full !== 1'b0) begin
        errors++; $display("FAIL wrap_level%0d level/full got %0d/%b want 2/0", b, w_level, w_full); end
      checks++; if (w_addr !== 3'(b)) begin errors++; $display("FAIL wrap_addr%0d got %0d want %0d", b, w_addr, 3'(b)); end
      @(posedge w_clk); #1;
      checks++; if (wptr_out !== gray(4'(b + 1))) begin errors++; $display("FAIL wrap_wptr%0d got %0d want %0d", b, wptr_out, gray(4'(b + 1))); end
    end
    w_en = 1'b0;
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      @(negedge w_clk); w_en = 1'b1;
      @(posedge w_clk); #1;
    end
    @(negedge w_clk);
    rptr_sync = 4'd2; #1;
    checks++; if (w_level !== 4'd5 || w_ovf !== OVF_EXP) begin
      errors++; $display("FAIL mid_pre level/ovf got %0d/%b want 5/%b", w_level, w_ovf, OVF_EXP); end
    w_rst = 1'b1; rptr_sync = 4'd0;
    @(posedge w_clk); #1;
    checks++; if (wptr_out !== 4'd0 || w_addr !== 3'd0 || w_level !== 4'd0) begin
      errors++; $display("FAIL mid_rst wptr/addr/level got %0d/%0d/%0d want 0/0/0", wptr_out, w_addr, w_level); end
    checks++; if (w_full !== 1'b0 || w_afull !== 1'b0 || w_ovf !== 1'b0) begin
      errors++; $display("FAIL mid_rst full/afull/ovf got %b/%b/%b want 0/0/0", w_full, w_afull, w_ovf); end
    @(negedge w_clk);
    w_rst = 1'b0;
    @(posedge w_clk); #1;
    w_en = 1'b0;
    checks++; if (wptr_out !== 4'd1 || w_addr !== 3'd1) begin
      errors++; $display("FAIL mid_post wptr/addr got %0d/%0d want 1/1", wptr_out, w_addr); end
  endtask

  initial begin
    w_rst = 1'b0; w_en = 1'b0; w_data = 8'h00; rptr_sync = 4'd0;
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
